// File: rtl/proj1_sweep_ctrl.sv
// Exhaustive truth-table sweep of a 3-input function: walks {x2,x1,x0} 0..7,
// samples z after a settle window per vector and compares against a latched mask.
module proj1_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_exp_mask,
  input  logic       i_z,
  output logic       o_x0,
  output logic       o_x1,
  output logic       o_x2,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic       o_pass,
  output logic       o_fail_valid,
  output logic [2:0] o_fail_idx
);

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_mask;
  logic [7:0] r_result;
  logic       r_pass;
  logic       r_fail_valid;
  logic [2:0] r_fail_idx;

  logic       w_accept;
  logic       w_active;
  logic       w_capture;
  logic [7:0] w_result_cap;
  logic [7:0] w_mismatch;
  logic [2:0] w_fail_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (i_abort)                      w_state_nxt = ST_IDLE;
        else if (r_cnt == LP_SETTLE_LAST) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (i_abort)            w_state_nxt = ST_IDLE;
        else if (r_idx == 3'd7) w_state_nxt = ST_DONE;
        else                    w_state_nxt = ST_SETTLE;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_active  = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign w_capture = (r_state == ST_SAMPLE) && !i_abort;

  // Final verdict must include the bit being captured on the same edge.
  always_comb begin
    w_result_cap        = r_result;
    w_result_cap[r_idx] = i_z;
  end

  assign w_mismatch = w_result_cap ^ r_mask;

  always_comb begin
    w_fail_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_mismatch[i]) w_fail_idx = 3'(i);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= 4'd0;
      r_idx        <= 3'd0;
      r_mask       <= 8'h00;
      r_result     <= 8'h00;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 3'd0;
    end else if (w_accept) begin
      r_cnt        <= 4'd0;
      r_idx        <= 3'd0;
      r_mask       <= i_exp_mask;
      r_result     <= 8'h00;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 3'd0;
    end else if (w_active && i_abort) begin
      r_cnt <= 4'd0;
      r_idx <= 3'd0;
    end else if (r_state == ST_SETTLE) begin
      r_cnt <= r_cnt + 4'd1;
    end else if (w_capture) begin
      r_result <= w_result_cap;
      if (r_idx != 3'd7) begin
        r_idx <= r_idx + 3'd1;
        r_cnt <= 4'd0;
      end else begin
        r_pass       <= (w_mismatch == 8'h00);
        r_fail_valid <= |w_mismatch;
        r_fail_idx   <= w_fail_idx;
      end
    end
  end

  assign {o_x2, o_x1, o_x0} = w_active ? r_idx : 3'd0;
  assign o_busy       = w_active;
  assign o_done       = (r_state == ST_DONE);
  assign o_result     = r_result;
  assign o_pass       = r_pass;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_proj1_sweep_ctrl.sv
// Directed bench for proj1_sweep_ctrl: one DUT with settle=2, one with settle=1.
module tb_proj1_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, start1;
  logic [7:0] mask, mask1;
  logic       z, z1;
  bit         zstuck;

  logic       x0, x1, x2, busy, done, pass, fv;
  logic [7:0] result;
  logic [2:0] fi;
  logic       x0_1, x1_1, x2_1, busy1, done1, pass1, fv1;
  logic [7:0] result1;
  logic [2:0] fi1;

  int checks = 0;
  int errors = 0;

  int         done_cyc, done_cnt, busy_cnt, both_cnt, x_bad;
  logic [7:0] res_at_done;
  logic       pass_at_done, fv_at_done;
  logic [2:0] fi_at_done;

  always #5 clk = ~clk;

  function automatic logic func(input logic [2:0] v);
    return (v == 3'd1) || (v == 3'd2) || (v == 3'd6);
  endfunction

  assign z  = zstuck ? 1'b1 : func({x2, x1, x0});
  assign z1 = func({x2_1, x1_1, x0_1});

  proj1_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_exp_mask(mask), .i_z(z),
    .o_x0(x0), .o_x1(x1), .o_x2(x2), .o_busy(busy), .o_done(done),
    .o_result(result), .o_pass(pass), .o_fail_valid(fv), .o_fail_idx(fi)
  );

  proj1_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(1'b0),
    .i_exp_mask(mask1), .i_z(z1),
    .o_x0(x0_1), .o_x1(x1_1), .o_x2(x2_1), .o_busy(busy1), .o_done(done1),
    .o_result(result1), .o_pass(pass1), .o_fail_valid(fv1), .o_fail_idx(fi1)
  );

  // Runs one sweep and records observations; cycle k is the k-th cycle after the accepting edge.
  task automatic sweep(input logic [7:0] m, input bit spam, input bit sel);
    int s, last;
    logic b, d;
    logic [2:0] xv, expx;
    s = sel ? 1 : 2;
    last = 8 * (s + 1);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; both_cnt = 0; x_bad = 0;
    @(negedge clk);
    if (sel) begin mask1 = m; start1 = 1'b1; end
    else     begin mask  = m; start  = 1'b1; end
    for (int k = 1; k <= last + 4; k++) begin
      @(negedge clk);
      if (sel) start1 = 1'b0;
      else     start  = spam && (k <= last + 1);
      b  = sel ? busy1 : busy;
      d  = sel ? done1 : done;
      xv = sel ? {x2_1, x1_1, x0_1} : {x2, x1, x0};
      expx = (k <= last) ? 3'((k - 1) / (s + 1)) : 3'd0;
      if (xv != expx) x_bad++;
      if (b) busy_cnt++;
      if (b && d) both_cnt++;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = k;
          res_at_done  = sel ? result1 : result;
          pass_at_done = sel ? pass1 : pass;
          fv_at_done   = sel ? fv1 : fv;
          fi_at_done   = sel ? fi1 : fi;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; start1 = 0; abort = 0; mask = 0; mask1 = 0; zstuck = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({x2, x1, x0, busy, done, result, pass, fv, fi} !== 17'h0) begin
      errors++; $display("FAIL reset_dut outputs=%h required 0", {x2, x1, x0, busy, done, result, pass, fv, fi});
    end
    checks++;
    if ({x2_1, x1_1, x0_1, busy1, done1, result1, pass1, fv1, fi1} !== 17'h0) begin
      errors++; $display("FAIL reset_dut1 outputs=%h required 0", {x2_1, x1_1, x0_1, busy1, done1, result1, pass1, fv1, fi1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct;
    sweep(8'h46, 1'b0, 1'b0);
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL correct_done_cycle got %0d required 25", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL correct_done_pulses got %0d required 1", done_cnt); end
    checks++; if (busy_cnt !== 24) begin errors++; $display("FAIL correct_busy_cycles got %0d required 24", busy_cnt); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL correct_busy_and_done got %0d required 0", both_cnt); end
    checks++; if (x_bad !== 0) begin errors++; $display("FAIL correct_x_walk bad_cycles %0d required 0", x_bad); end
    checks++; if (res_at_done !== 8'h46) begin errors++; $display("FAIL correct_result got %h required 46", res_at_done); end
    checks++; if ({pass_at_done, fv_at_done} !== 2'b10) begin errors++; $display("FAIL correct_pass_fv got %b required 10", {pass_at_done, fv_at_done}); end
    checks++; if ({result, pass, fv} !== {8'h46, 2'b10}) begin errors++; $display("FAIL correct_hold got %h/%b%b required 46/10", result, pass, fv); end
  endtask

  task automatic test_mask_mismatch;
    sweep(8'h47, 1'b0, 1'b0);
    checks++; if (res_at_done !== 8'h46) begin errors++; $display("FAIL mismatch_result got %h required 46", res_at_done); end
    checks++; if ({pass_at_done, fv_at_done, fi_at_done} !== 5'b01_000) begin
      errors++; $display("FAIL mismatch_verdict pass/fv/idx got %b/%b/%0d required 0/1/0", pass_at_done, fv_at_done, fi_at_done);
    end
  endtask

  task automatic test_stuck;
    zstuck = 1'b1;
    sweep(8'h46, 1'b0, 1'b0);
    checks++; if (res_at_done !== 8'hFF) begin errors++; $display("FAIL stuck_result got %h required ff", res_at_done); end
    checks++; if ({pass_at_done, fv_at_done, fi_at_done} !== 5'b01_000) begin
      errors++; $display("FAIL stuck46_verdict pass/fv/idx got %b/%b/%0d required 0/1/0", pass_at_done, fv_at_done, fi_at_done);
    end
    sweep(8'hFE, 1'b0, 1'b0);
    checks++; if ({pass_at_done, fv_at_done, fi_at_done} !== 5'b01_000) begin
      errors++; $display("FAIL stuckfe_verdict pass/fv/idx got %b/%b/%0d required 0/1/0", pass_at_done, fv_at_done, fi_at_done);
    end
    sweep(8'hFF, 1'b0, 1'b0);
    checks++; if ({pass_at_done, fv_at_done, fi_at_done} !== 5'b10_000) begin
      errors++; $display("FAIL stuckff_verdict pass/fv/idx got %b/%b/%0d required 1/0/0", pass_at_done, fv_at_done, fi_at_done);
    end
    zstuck = 1'b0;
  endtask

  task automatic test_start_spam;
    sweep(8'h46, 1'b1, 1'b0);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL spam_done_pulses got %0d required 1", done_cnt); end
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL spam_done_cycle got %0d required 25", done_cyc); end
    checks++; if (busy_cnt !== 24) begin errors++; $display("FAIL spam_busy_cycles got %0d required 24", busy_cnt); end
    checks++; if (x_bad !== 0) begin errors++; $display("FAIL spam_x_walk bad_cycles %0d required 0", x_bad); end
    checks++; if (res_at_done !== 8'h46) begin errors++; $display("FAIL spam_result got %h required 46", res_at_done); end
  endtask

  task automatic test_abort;
    int dn;
    dn = 0;
    @(negedge clk); mask = 8'h46; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        checks++;
        if ({busy, x2, x1, x0} !== 4'b1011) begin errors++; $display("FAIL abort_pre busy/x got %b required 1011", {busy, x2, x1, x0}); end
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, x2, x1, x0} !== 5'b0) begin errors++; $display("FAIL abort_state busy/done/x got %b required 00000", {busy, done, x2, x1, x0}); end
    checks++;
    if ({result, pass, fv} !== {8'h06, 2'b00}) begin errors++; $display("FAIL abort_result got %h/%b%b required 06/00", result, pass, fv); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_quiet active_cycles %0d required 0", dn); end
    sweep(8'h46, 1'b0, 1'b0);
    checks++; if ({res_at_done, pass_at_done} !== {8'h46, 1'b1}) begin errors++; $display("FAIL abort_resweep got %h/%b required 46/1", res_at_done, pass_at_done); end
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL abort_resweep_cycle got %0d required 25", done_cyc); end
  endtask

  task automatic test_rst_mid;
    @(negedge clk); mask = 8'h46; start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({busy, x2, x1, x0} !== 4'b1101) begin errors++; $display("FAIL rst_pre busy/x got %b required 1101", {busy, x2, x1, x0}); end
    rst = 1'b1;
    #1;
    checks++;
    if ({x2, x1, x0, busy, done, result, pass, fv, fi} !== 17'h0) begin
      errors++; $display("FAIL rst_mid outputs=%h required 0", {x2, x1, x0, busy, done, result, pass, fv, fi});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_hold busy/done got %b required 00", {busy, done}); end
    rst = 1'b0;
    sweep(8'h46, 1'b0, 1'b0);
    checks++; if ({res_at_done, pass_at_done, fv_at_done} !== {8'h46, 2'b10}) begin
      errors++; $display("FAIL rst_resweep got %h/%b%b required 46/10", res_at_done, pass_at_done, fv_at_done);
    end
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL rst_resweep_cycle got %0d required 25", done_cyc); end
  endtask

  task automatic test_settle1;
    sweep(8'h46, 1'b0, 1'b1);
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL s1_done_cycle got %0d required 17", done_cyc); end
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL s1_busy_cycles got %0d required 16", busy_cnt); end
    checks++; if (x_bad !== 0) begin errors++; $display("FAIL s1_x_walk bad_cycles %0d required 0", x_bad); end
    checks++; if ({res_at_done, pass_at_done, done_cnt} !== {8'h46, 1'b1, 32'd1}) begin
      errors++; $display("FAIL s1_result got %h/%b pulses %0d required 46/1 pulses 1", res_at_done, pass_at_done, done_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_correct();
    test_mask_mismatch();
    test_stuck();
    test_start_spam();
    test_abort();
    test_rst_mid();
    test_settle1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
